ex_mem_pipe_reg: RTL and testbench



---
 rtl/ex_mem_pkg.sv | 20 ++
 rtl/pipe_skid_buf.sv | 106 ++++++++++
 rtl/ex_mem_pipe_reg.sv | 80 ++++++++
 tb/tb_ex_mem_pipe_reg.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_pkg.sv
// Shared types and default widths for the EX->MEM pipeline stage register.
package ex_mem_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } skidState_t;

    localparam int DATA_W_DEF  = 8;
    localparam int LABEL_W_DEF = 8;

    // label value + label flag + mem_wr + mem_rd + alu result + operand A + operand B
    function automatic int payloadWidth(input int labelW, input int dataW);
        return labelW + dataW * 3 + 3;
    endfunction

    localparam int PAYLOAD_W_DEF = payloadWidth(LABEL_W_DEF, DATA_W_DEF);

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with synchronous flush.
// in_ready is decoded from the state register only, so out_ready never reaches it combinationally.
//
//   state | meaning
//   EMPTY | nothing held, outValid low
//   HALF  | main register holds the oldest entry
//   FULL  | main holds the oldest, skid holds the next; upstream stalled
module pipe_skid_buf
    import ex_mem_pkg::*;
#(
    parameter int               WIDTH    = PAYLOAD_W_DEF,
    parameter logic [WIDTH-1:0] CLR_MASK = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] inData,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] outData
);

    skidState_t       stateQ;
    skidState_t       stateNext;
    logic [WIDTH-1:0] mainQ;
    logic [WIDTH-1:0] skidQ;
    logic             acc;
    logic             con;
    logic             loadMain;
    logic             loadSkid;
    logic             mainFromSkid;

    assign inReady  = (stateQ != FULL);
    assign outValid = (stateQ != EMPTY);
    assign outData  = mainQ;

    assign acc = inValid & inReady & ~flush;
    assign con = outValid & outReady;

    always_comb begin
        stateNext    = stateQ;
        loadMain     = 1'b0;
        loadSkid     = 1'b0;
        mainFromSkid = 1'b0;
        case (stateQ)
            EMPTY: begin
                if (acc) begin
                    loadMain  = 1'b1;
                    stateNext = HALF;
                end
            end
            HALF: begin
                if (acc && con) begin
                    loadMain = 1'b1;
                end else if (acc) begin
                    loadSkid  = 1'b1;
                    stateNext = FULL;
                end else if (con) begin
                    stateNext = EMPTY;
                end
            end
            FULL: begin
                if (con) begin
                    mainFromSkid = 1'b1;
                    stateNext    = HALF;
                end
            end
            default: stateNext = EMPTY;
        endcase
        if (flush) begin
            stateNext = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= EMPTY;
        end else begin
            stateQ <= stateNext;
        end
    end

    // Flush only scrubs the masked bits; the rest of the main register may go stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mainQ <= '0;
        end else if (flush) begin
            mainQ <= mainQ & ~CLR_MASK;
        end else if (loadMain) begin
            mainQ <= inData;
        end else if (mainFromSkid) begin
            mainQ <= skidQ;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skidQ <= '0;
        end else if (loadSkid) begin
            skidQ <= inData;
        end
    end

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline stage register: packs the execute bundle through a skid buffer.
// Define EX_MEM_STALL_CNT_EN to add the saturating stall_cnt output.
module ex_mem_pipe_reg
    import ex_mem_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int LABEL_W = LABEL_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LABEL_W-1:0] in_label_value,
    input  logic               in_label_flag,
    input  logic               in_mem_wr,
    input  logic               in_mem_rd,
    input  logic [DATA_W-1:0]  in_alu_result,
    input  logic [DATA_W-1:0]  in_reg_a,
    input  logic [DATA_W-1:0]  in_reg_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LABEL_W-1:0] out_label_value,
    output logic               out_label_flag,
    output logic               out_mem_wr,
    output logic               out_mem_rd,
    output logic [DATA_W-1:0]  out_alu_result,
    output logic [DATA_W-1:0]  out_reg_a,
    output logic [DATA_W-1:0]  out_reg_b
`ifdef EX_MEM_STALL_CNT_EN
    ,
    output logic [15:0]        stall_cnt
`endif
);

    localparam int PW = payloadWidth(LABEL_W, DATA_W);

    // Label flag and both memory strobes are cleared on flush so a dead slot has no side effect.
    localparam logic [PW-1:0] FLAG_MASK = {{LABEL_W{1'b0}}, 3'b111, {(3 * DATA_W){1'b0}}};

    logic [PW-1:0] inData;
    logic [PW-1:0] outData;

    assign inData = {in_label_value, in_label_flag, in_mem_wr, in_mem_rd,
                     in_alu_result, in_reg_a, in_reg_b};

    assign {out_label_value, out_label_flag, out_mem_wr, out_mem_rd,
            out_alu_result, out_reg_a, out_reg_b} = outData;

    pipe_skid_buf #(
        .WIDTH    (PW),
        .CLR_MASK (FLAG_MASK)
    ) uSkidBuf (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .inValid  (in_valid),
        .inReady  (in_ready),
        .inData   (inData),
        .outValid (out_valid),
        .outReady (out_ready),
        .outData  (outData)
    );

`ifdef EX_MEM_STALL_CNT_EN
    logic [15:0] stallCntQ;

    // Survives flush on purpose: it measures MEM back-pressure, not pipeline contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCntQ <= '0;
        end else if (out_valid && !out_ready && (stallCntQ != 16'hFFFF)) begin
            stallCntQ <= stallCntQ + 16'd1;
        end
    end

    assign stall_cnt = stallCntQ;
`endif

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Self-checking bench for ex_mem_pipe_reg against a queue-based reference model.
module tb_ex_mem_pipe_reg;

    localparam int DW = 8;
    localparam int LW = 8;

    typedef struct packed {
        logic [LW-1:0] labelValue;
        logic          labelFlag;
        logic          memWr;
        logic          memRd;
        logic [DW-1:0] aluResult;
        logic [DW-1:0] regA;
        logic [DW-1:0] regB;
    } entry_t;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b1;
    logic          flush     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    entry_t        inEntry   = '0;
    logic          in_ready;
    logic          out_valid;
    logic [LW-1:0] out_label_value;
    logic          out_label_flag;
    logic          out_mem_wr;
    logic          out_mem_rd;
    logic [DW-1:0] out_alu_result;
    logic [DW-1:0] out_reg_a;
    logic [DW-1:0] out_reg_b;
`ifdef EX_MEM_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    ex_mem_pipe_reg #(.DATA_W(DW), .LABEL_W(LW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_label_value  (inEntry.labelValue),
        .in_label_flag   (inEntry.labelFlag),
        .in_mem_wr       (inEntry.memWr),
        .in_mem_rd       (inEntry.memRd),
        .in_alu_result   (inEntry.aluResult),
        .in_reg_a        (inEntry.regA),
        .in_reg_b        (inEntry.regB),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_label_value (out_label_value),
        .out_label_flag  (out_label_flag),
        .out_mem_wr      (out_mem_wr),
        .out_mem_rd      (out_mem_rd),
        .out_alu_result  (out_alu_result),
        .out_reg_a       (out_reg_a),
        .out_reg_b       (out_reg_b)
`ifdef EX_MEM_STALL_CNT_EN
        ,
        .stall_cnt       (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    entry_t        modelQ[$];
    logic [DW-1:0] seenAlu[$];
    int unsigned   modelStall = 0;
    bit            flagsClear = 1'b1;
    int            nChecks    = 0;
    int            nFails     = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic entry_t dut_entry();
        entry_t e;
        e = {out_label_value, out_label_flag, out_mem_wr, out_mem_rd,
             out_alu_result, out_reg_a, out_reg_b};
        return e;
    endfunction

    function automatic entry_t rand_entry(input logic [DW-1:0] alu);
        entry_t e;
        e.labelValue = LW'($urandom);
        e.labelFlag  = 1'($urandom);
        e.memWr      = 1'($urandom);
        e.memRd      = 1'($urandom);
        e.aluResult  = alu;
        e.regA       = DW'($urandom);
        e.regB       = DW'($urandom);
        return e;
    endfunction

    task automatic check_outputs();
        check_eq("out_valid", 64'(out_valid), 64'(modelQ.size() != 0));
        check_eq("in_ready", 64'(in_ready), 64'(modelQ.size() < 2));
        if (modelQ.size() != 0) begin
            check_eq("payload", 64'(dut_entry()), 64'(modelQ[0]));
        end else if (flagsClear) begin
            check_eq("idle_flags", 64'({out_label_flag, out_mem_wr, out_mem_rd}), 64'(0));
        end
`ifdef EX_MEM_STALL_CNT_EN
        check_eq("stall_cnt_model", 64'(stall_cnt), 64'(modelStall));
`endif
    endtask

    // One clock: model decides from pre-edge inputs, then outputs are compared 1 time unit after the edge.
    task automatic cycle(output bit accepted);
        bit acc;
        bit con;
        acc = in_valid && (modelQ.size() < 2) && !flush;
        con = (modelQ.size() != 0) && out_ready;
        if ((modelQ.size() != 0) && !out_ready && (modelStall < 32'hFFFF)) modelStall++;
        if (con && !flush) seenAlu.push_back(out_alu_result);
        @(posedge clk);
        if (flush) begin
            modelQ.delete();
            flagsClear = 1'b1;
        end else begin
            if (con) void'(modelQ.pop_front());
            if (acc) begin
                modelQ.push_back(inEntry);
                flagsClear = 1'b0;
            end
        end
        accepted = acc;
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) cycle(a);
    endtask

    task automatic send(input entry_t e);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        inEntry  = e;
        for (int i = 0; i < 20 && !done; i++) cycle(done);
        in_valid = 1'b0;
        check_eq("send_accepted", 64'(done), 64'(1));
    endtask

    task automatic check_all_zero(input string tag);
        check_eq(tag, 64'({out_valid, out_label_value, out_label_flag, out_mem_wr, out_mem_rd,
                          out_alu_result, out_reg_a, out_reg_b}), 64'(0));
    endtask

    initial begin
        entry_t e;
        int     sent;
        bit     acc;

        // Power-on reset
        #1 rst_n = 1'b0;
        #2 check_all_zero("reset_outputs");
        @(negedge clk) rst_n = 1'b1;
        #1 check_eq("reset_in_ready", 64'(in_ready), 64'(1));

        // Back-to-back stream, one cycle latency
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            send(rand_entry(DW'(8'h11 * i)));
            check_eq("stream_valid", 64'(out_valid), 64'(1));
            check_eq("stream_alu", 64'(out_alu_result), 64'(8'h11 * i));
        end
        idle(2);

        // Stall with third entry held upstream
        seenAlu.delete();
        out_ready = 1'b0;
        send(rand_entry(8'hA1));
        send(rand_entry(8'hA2));
        check_eq("stall_in_ready", 64'(in_ready), 64'(0));
        in_valid = 1'b1;
        inEntry  = rand_entry(8'hA3);
        idle(3);
        check_eq("stall_hold_alu", 64'(out_alu_result), 64'(8'hA1));
        check_eq("stall_hold_rdy", 64'(in_ready), 64'(0));
        out_ready = 1'b1;
        send(inEntry);
        idle(3);
        check_eq("stall_count", 64'(seenAlu.size()), 64'(3));
        if (seenAlu.size() == 3) begin
            check_eq("stall_order0", 64'(seenAlu[0]), 64'(8'hA1));
            check_eq("stall_order1", 64'(seenAlu[1]), 64'(8'hA2));
            check_eq("stall_order2", 64'(seenAlu[2]), 64'(8'hA3));
        end

        // Flush while FULL with a write entry arriving
        seenAlu.delete();
        out_ready = 1'b0;
        send(rand_entry(8'hB1));
        send(rand_entry(8'hB2));
        e = rand_entry(8'hEE);
        e.memWr = 1'b1;
        e.memRd = 1'b1;
        e.labelFlag = 1'b1;
        inEntry  = e;
        in_valid = 1'b1;
        flush    = 1'b1;
        cycle(acc);
        flush    = 1'b0;
        in_valid = 1'b0;
        check_eq("flush_valid", 64'(out_valid), 64'(0));
        check_eq("flush_mem_wr", 64'(out_mem_wr), 64'(0));
        check_eq("flush_mem_rd", 64'(out_mem_rd), 64'(0));
        check_eq("flush_label_flag", 64'(out_label_flag), 64'(0));
        check_eq("flush_in_ready", 64'(in_ready), 64'(1));
        out_ready = 1'b1;
        idle(3);
        check_eq("flush_nothing_out", 64'(seenAlu.size()), 64'(0));

        // Random traffic, out_ready toggling every cycle
        seenAlu.delete();
        sent = 0;
        e = rand_entry(DW'($urandom));
        for (int i = 0; i < 300 && (sent < 20 || modelQ.size() != 0); i++) begin
            out_ready = ~out_ready;
            in_valid  = (sent < 20) && ($urandom_range(0, 3) != 0);
            inEntry   = e;
            cycle(acc);
            if (acc) begin
                sent++;
                e = rand_entry(DW'($urandom));
            end
        end
        in_valid = 1'b0;
        check_eq("random_sent", 64'(sent), 64'(20));
        check_eq("random_drained", 64'(seenAlu.size()), 64'(20));

        // Reset asserted mid-transfer clears outputs without an edge
        out_ready = 1'b0;
        send(rand_entry(8'hC1));
        send(rand_entry(8'hC2));
        #2 rst_n = 1'b0;
        #1 check_all_zero("midreset_outputs");
        modelQ.delete();
        modelStall = 0;
        flagsClear = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 check_outputs();

`ifdef EX_MEM_STALL_CNT_EN
        // Stall counter: five stalled cycles, then a flush must not clear it
        out_ready = 1'b0;
        send(rand_entry(8'hD1));
        idle(5);
        check_eq("stall_cnt_5", 64'(stall_cnt), 64'(5));
        out_ready = 1'b1;
        flush     = 1'b1;
        cycle(acc);
        flush     = 1'b0;
        check_eq("stall_cnt_flush", 64'(stall_cnt), 64'(5));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
